// File: rtl/pixel_write.sv
// rtl/pixel_write.sv - packs a raster pixel stream into 64-bit SRAM words with per-row partial-word flush.
// Optional PIXW_BORDER_ZERO_EN forces frame-border pixels to 0x00.
module pixel_write #(
  parameter int AW = 21,
  parameter int DW = 64,
  parameter int BW = 8
) (
  input  logic          pclk,
  input  logic          prst,
  input  logic          write_start,
  input  logic [AW-1:0] wr_base,
  input  logic [15:0]   frame_width,
  input  logic [15:0]   frame_height,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [AW-1:0] w_adr,
  output logic [BW-1:0] wen,
  output logic [DW-1:0] result,
  output logic          busy,
  output logic          write_finish
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] base_r;
  logic [15:0]   width_r;
  logic [15:0]   height_r;
  logic [AW-1:0] wpr_r;
  logic [15:0]   col;
  logic [15:0]   row;
  logic [AW-1:0] row_base;
  logic [DW-1:0] pack;
  logic [BW-1:0] mask;

  logic [2:0]    lane;
  logic          last_col;
  logic          last_row;
  logic          emit;
  logic [7:0]    pix_byte;
  logic [DW-1:0] pack_next;
  logic [BW-1:0] mask_next;
  logic [13:0]   wpr_next;

  assign lane     = col[2:0];
  assign last_col = (col == width_r - 16'd1);
  assign last_row = (row == height_r - 16'd1);
  assign emit     = (lane == 3'd7) || last_col;
  // Words per row rounds up so a partial trailing word still gets its own address.
  assign wpr_next = 14'(({1'b0, frame_width} + 17'd7) >> 3);

`ifdef PIXW_BORDER_ZERO_EN
  always_comb begin
    pix_byte = pix_in;
    if (row == 16'd0 || last_row || col == 16'd0 || last_col)
      pix_byte = 8'h00;
  end
`else
  assign pix_byte = pix_in;
`endif

  always_comb begin
    pack_next = pack;
    mask_next = mask;
    pack_next[8*lane +: 8] = pix_byte;
    mask_next[lane]        = 1'b1;
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state        <= S_IDLE;
      base_r       <= '0;
      width_r      <= '0;
      height_r     <= '0;
      wpr_r        <= '0;
      col          <= '0;
      row          <= '0;
      row_base     <= '0;
      pack         <= '0;
      mask         <= '0;
      pix_ready    <= 1'b0;
      w_adr        <= '0;
      wen          <= '0;
      result       <= '0;
      busy         <= 1'b0;
      write_finish <= 1'b0;
    end else begin
      wen          <= '0;
      write_finish <= 1'b0;
      case (state)
        S_IDLE: begin
          if (write_start) begin
            if (frame_width == 16'd0 || frame_height == 16'd0) begin
              state        <= S_DONE;
              write_finish <= 1'b1;
            end else begin
              base_r    <= wr_base;
              width_r   <= frame_width;
              height_r  <= frame_height;
              wpr_r     <= AW'(wpr_next);
              col       <= '0;
              row       <= '0;
              row_base  <= '0;
              pack      <= '0;
              mask      <= '0;
              pix_ready <= 1'b1;
              busy      <= 1'b1;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (pix_valid && pix_ready) begin
            if (emit) begin
              wen    <= mask_next;
              result <= pack_next;
              w_adr  <= base_r + row_base + AW'(col[15:3]);
              pack   <= '0;
              mask   <= '0;
            end else begin
              pack <= pack_next;
              mask <= mask_next;
            end
            if (last_col) begin
              col      <= '0;
              row      <= row + 16'd1;
              row_base <= row_base + wpr_r;
              if (last_row) begin
                pix_ready <= 1'b0;
                state     <= S_FLUSH;
              end
            end else begin
              col <= col + 16'd1;
            end
          end
        end
        // Final word is on the write port during this cycle.
        S_FLUSH: begin
          busy         <= 1'b0;
          write_finish <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write.sv
// tb/tb_pixel_write.sv - directed bench for pixel_write with a write-port scoreboard.
module tb_pixel_write;
  localparam int AW = 21;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          pclk;
  logic          prst;
  logic          write_start;
  logic [AW-1:0] wr_base;
  logic [15:0]   frame_width;
  logic [15:0]   frame_height;
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [AW-1:0] w_adr;
  logic [BW-1:0] wen;
  logic [DW-1:0] result;
  logic          busy;
  logic          write_finish;

  pixel_write #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .pclk(pclk), .prst(prst), .write_start(write_start), .wr_base(wr_base),
    .frame_width(frame_width), .frame_height(frame_height), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .w_adr(w_adr), .wen(wen),
    .result(result), .busy(busy), .write_finish(write_finish)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [AW-1:0] adr;
    logic [BW-1:0] wen;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int r, input int c, input int w);
    if (mode == 1) return 8'hAA;
    return 8'((r * w + c) & 255);
  endfunction

  function automatic logic [7:0] exp_byte(input int mode, input int r, input int c, input int w, input int h);
    logic [7:0] v;
    v = pix_val(mode, r, c, w);
`ifdef PIXW_BORDER_ZERO_EN
    if (r == 0 || r == h - 1 || c == 0 || c == w - 1) v = 8'h00;
`else
    if (h < 0) v = 8'h00;
`endif
    return v;
  endfunction

  always @(negedge pclk) begin
    if (!prst && wen !== '0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", 64'(wen), 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("w_adr", 64'(w_adr), 64'(e.adr));
        chk("wen", 64'(wen), 64'(e.wen));
        chk("result", result, e.data);
      end
    end
  end

  task automatic run_frame(input logic [AW-1:0] base, input int w, input int h,
                           input bit gaps, input int mode, input bit inject);
    int wpr;
    wpr = (w + 7) / 8;
    for (int r = 0; r < h; r++) begin
      for (int j = 0; j < wpr; j++) begin
        wr_t e;
        e.adr  = base + AW'(r * wpr + j);
        e.wen  = '0;
        e.data = '0;
        for (int k = 0; k < 8; k++) begin
          if (8 * j + k < w) begin
            e.wen[k]          = 1'b1;
            e.data[8*k +: 8]  = exp_byte(mode, r, 8 * j + k, w, h);
          end
        end
        exp_q.push_back(e);
      end
    end
    write_start  = 1'b1;
    wr_base      = base;
    frame_width  = 16'(w);
    frame_height = 16'(h);
    @(posedge pclk); #1;
    write_start = 1'b0;
    chk("start_pix_ready", 64'(pix_ready), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        pix_valid = 1'b1;
        pix_in    = pix_val(mode, r, c, w);
        if (inject && r == 0 && c == 3) begin
          write_start = 1'b1;
          wr_base     = base + AW'(100);
          frame_width = 16'd3;
        end
        @(posedge pclk); #1;
        write_start = 1'b0;
        wr_base     = base;
        frame_width = 16'(w);
        if (gaps && !(r == h - 1 && c == w - 1)) begin
          pix_valid = 1'b0;
          pix_in    = 8'h5A;
          @(posedge pclk); #1;
        end
      end
    end
    pix_valid = 1'b0;
    chk("flush_busy", 64'(busy), 64'd1);
    chk("flush_pix_ready", 64'(pix_ready), 64'd0);
    chk("flush_finish_low", 64'(write_finish), 64'd0);
    @(posedge pclk); #1;
    chk("finish_pulse", 64'(write_finish), 64'd1);
    chk("finish_busy_low", 64'(busy), 64'd0);
    @(posedge pclk); #1;
    chk("finish_one_cycle", 64'(write_finish), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    prst = 1'b1; write_start = 1'b0; wr_base = '0; frame_width = '0;
    frame_height = '0; pix_in = '0; pix_valid = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("rst_w_adr", 64'(w_adr), 64'd0);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_finish", 64'(write_finish), 64'd0);
    prst = 1'b0;
    @(posedge pclk); #1;

    run_frame(21'h100, 16, 2, 1'b0, 0, 1'b0);
    run_frame(21'h200, 10, 2, 1'b0, 0, 1'b1);
    run_frame(21'h300, 8, 1, 1'b1, 0, 1'b0);

    write_start = 1'b1; frame_width = 16'd8; frame_height = 16'd0;
    @(posedge pclk); #1;
    write_start = 1'b0;
    chk("zero_h_finish", 64'(write_finish), 64'd1);
    chk("zero_h_busy", 64'(busy), 64'd0);
    chk("zero_h_ready", 64'(pix_ready), 64'd0);
    @(posedge pclk); #1;
    chk("zero_h_finish_end", 64'(write_finish), 64'd0);

    write_start = 1'b1; frame_width = 16'd0; frame_height = 16'd4;
    @(posedge pclk); #1;
    write_start = 1'b0;
    chk("zero_w_finish", 64'(write_finish), 64'd1);
    @(posedge pclk); #1;

    write_start = 1'b1; wr_base = 21'h400; frame_width = 16'd8; frame_height = 16'd1;
    @(posedge pclk); #1;
    write_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      pix_valid = 1'b1; pix_in = 8'(c + 1);
      @(posedge pclk); #1;
    end
    pix_valid = 1'b0;
    prst = 1'b1;
    @(posedge pclk); #1;
    chk("mid_rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("mid_rst_w_adr", 64'(w_adr), 64'd0);
    chk("mid_rst_wen", 64'(wen), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    prst = 1'b0;
    @(posedge pclk); #1;
    chk("mid_rst_no_write", 64'(wen), 64'd0);

    run_frame(21'h400, 8, 1, 1'b0, 0, 1'b0);
    run_frame(21'h500, 8, 3, 1'b0, 1, 1'b0);
    run_frame(21'h1FFFFF, 16, 1, 1'b0, 0, 1'b0);

    repeat (3) @(posedge pclk);
    #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_write.md
# pixel_write

Write-back end of the median-filter datapath: accepts the filtered 8-bit pixel stream in raster order, packs eight pixels per 64-bit word, and drives the SRAM write port (`w_adr`, `wen`, `result`). It tracks column/row position, flushes a partial word with partial byte enables at each row end, and pulses `write_finish` when the last pixel of the frame has been committed to memory. It sits between the median core output and the `sram_2Mx64` write side, mirroring the pixel reader on the read side.

## Interface
- `AW`, 21, SRAM word-address width
- `DW`, 64, SRAM data width
- `BW`, 8, byte-enable width (`DW/8`)

- `pclk`  in  1  sole clock; all state on rising edge
- `prst`  in  1  asynchronous, active-high reset
- `write_start`  in  1  one-cycle pulse; latches `wr_base`, `frame_width`, `frame_height`
- `wr_base`  in  AW  word address of pixel (0,0)
- `frame_width`  in  16  pixels per row
- `frame_height`  in  16  rows per frame
- `pix_in`  in  8  filtered pixel
- `pix_valid`  in  1  `pix_in` valid
- `pix_ready`  out  1  block accepts pixel this cycle
- `w_adr`  out  AW  SRAM write word address
- `wen`  out  BW  active-high byte enables; all-zero = no write
- `result`  out  DW  SRAM write data; byte k = pixel at column `8*word+k`
- `busy`  out  1  frame in progress (RUN or FLUSH)
- `write_finish`  out  1  one-cycle pulse after last word issued

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: `pix_ready`=0. On `write_start`: if `frame_width`==0 or `frame_height`==0 → DONE, else latch config, clear col/row/lane, → RUN. `write_start` outside IDLE ignored.
- RUN: `pix_ready`=1. Each accepted pixel (`pix_valid & pix_ready`) stored at byte lane = `col[2:0]` of the pack register, lane bit set in pending-enable mask.
- Word emission when the accepted pixel is lane 7 or the last column (`col == frame_width-1`): next cycle `wen` = pending mask, `result` = pack register, `w_adr` = `wr_base + row*wpr + (col>>3)`, where `wpr = (frame_width+7)>>3`. Mask and pack register clear in the same cycle.
- Unwritten lanes in a partial word drive 0x00 in `result` and have `wen` bit 0; memory bytes there are preserved.
- End of row: col→0, row++. After last column of last row: RUN → FLUSH (no more `pix_ready`).
- FLUSH: lasts one cycle while final word is on the write port; → DONE.
- DONE: `write_finish`=1 for exactly one cycle; → IDLE.
- Address arithmetic: `row*wpr` computed incrementally (row-base register += `wpr` per row), AW bits, wraps modulo 2^AW.

## Timing
- Reset values: `pix_ready`=0, `w_adr`=0, `wen`=0, `result`=0, `busy`=0, `write_finish`=0; state IDLE; all counters 0.
- `write_start` in cycle N → `pix_ready`=1 and `busy`=1 from N+1.
- Pixel accepted in cycle M completing a word → `wen`≠0 in cycle M+1 only; `wen`=0 every other cycle.
- One pixel per cycle sustained; `pix_valid` gaps stall counters without emitting.
- Last pixel accepted cycle L: final write at L+1 (FLUSH), `write_finish` at L+2, `busy` low at L+2.
- Zero dimension: `write_start` at N → `write_finish` at N+1, no writes.
- `prst` mid-frame: immediate return to reset values; pending partial word discarded, never written.

## Configuration
- `PIXW_BORDER_ZERO_EN` defined: pixels in row 0, row `frame_height-1`, column 0, column `frame_width-1` are written as 0x00 regardless of `pix_in` (pixel still consumed; byte enable still set).
- Undefined: every pixel written as received.

## Test plan
- `wr_base`=0x100, 16x2 frame, pixels 0..31 continuous → 4 writes at 0x100,0x101,0x102,0x103, `wen`=0xFF each, word 0 `result`=0x0706050403020100; `write_finish` 2 cycles after pixel 31.
- 10x2 frame → writes at base, base+1 (`wen`=0x03), base+2, base+3 (`wen`=0x03); upper bytes of partial words 0x00.
- 8x1 frame with `pix_valid` toggling every other cycle → single write, `wen`=0xFF, no spurious writes during gaps.
- `frame_height`=0 → no `wen`, `write_finish` at N+1; `write_start` while `busy` → ignored, frame unaffected.
- `prst` asserted after 5 pixels of 8x1 frame → all outputs 0 next edge, no write issued; subsequent `write_start` runs a clean frame.
- With `PIXW_BORDER_ZERO_EN`, 8x3 frame all 0xAA → row 0 and row 2 words 0x0; row 1 word 0x00AAAAAAAAAAAA00.
